alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the combinational datapath ALU. It keeps the same 8-opcode set and the low/high result split.
- Adds a WIDTH parameter, a registered valid/ready handshake on input and output, an iterative shift-add signed multiplier, and an add/sub overflow flag.
- Sits between the decode/operand-fetch stage and register writeback. Writeback consumes o_low/o_high/write_high when out_valid && out_ready.

Parameters:
- WIDTH, 16: operand width in bits. Legal range 4..64. Results are 2*WIDTH bits, split into o_high and o_low.
- CNT_W, $clog2(WIDTH+1): width of the multiply iteration counter. Derived; not overridden.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  opcode and operands are valid this cycle.
- in_ready  out  1  block accepts an operation this cycle.
- opcode  in  3  operation select: 000 ADD, 001 SUB, 010 MUL, 011 SH, 100 XOR, 101 AND, 110 OR, 111 NOT.
- s0  in  WIDTH  operand 0, two's complement.
- s1  in  WIDTH  operand 1. Two's complement, except for SH, where it is an unsigned shift amount.
- out_valid  out  1  result registers hold an unconsumed result.
- out_ready  in  1  downstream consumes the result this cycle.
- o_low  out  WIDTH  low half of the result.
- o_high  out  WIDTH  high half of the result.
- write_high  out  1  writeback must also store o_high. Set for MUL and SH only.
- ovf  out  1  signed overflow for ADD/SUB; 0 for all other opcodes.
- busy  out  1  multiplier is iterating.

Behaviour:
- Reset: asynchronous, rst_n low.
  - State goes to IDLE.
  - out_valid, o_low, o_high, write_high, ovf, busy and the counter all go to 0.
  - Asserting reset mid-multiply aborts the operation; no result is produced.
- States: IDLE, BUSY, HOLD.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). It is combinational and never depends on in_valid.
- Accept: an operation is accepted on a rising edge where in_valid && in_ready. Inputs are sampled only at accept; they may change freely afterwards.
- Single-cycle ops (all opcodes except MUL): the result registers are loaded at the accept edge and the next state is HOLD. out_valid therefore rises one cycle after accept (latency 1).
- ADD/SUB:
  - o_low = s0 + s1, or s0 - s1, truncated to WIDTH bits; o_high = 0.
  - ovf = 1 when the operand signs make the true result unrepresentable: ADD with equal operand signs and a differing result sign, or SUB with differing operand signs and a result sign different from s0.
- XOR/AND/OR: o_low = bitwise s0 op s1. NOT: o_low = ~s0. For all four, o_high = 0.
- SH:
  - {o_high,o_low} = zero-extended s0, shifted left by unsigned s1.
  - If s1 >= 2*WIDTH the result is 0.
- MUL:
  - At the accept edge, latch |s0|, |s1| and the result sign (s0 sign XOR s1 sign). Clear the accumulator and the counter; next state is BUSY; busy = 1.
  - In BUSY, one multiplier bit is processed per cycle, LSB first, by shift-add on the magnitudes. The counter increments every cycle.
  - After WIDTH BUSY cycles, load {o_high,o_low} with the 2*WIDTH-bit two's complement product (the magnitude product, negated if the sign bit is set). At the same time set write_high = 1 and busy = 0, and go to HOLD.
  - out_valid rises WIDTH+1 cycles after accept.
  - The most-negative operand is handled correctly because magnitudes are held in WIDTH+1 bits.
  - in_ready = 0 throughout BUSY.
- HOLD:
  - out_valid = 1. The outputs hold stable until out_ready.
  - If out_ready is high and no new operation is accepted, go to IDLE and clear out_valid. The o_* registers keep their last value.
  - If out_ready is high and a single-cycle op is accepted in the same cycle (back-to-back), reload the result registers and stay in HOLD, giving one op per cycle.
  - If out_ready is high and a MUL is accepted in the same cycle, clear out_valid and go to BUSY.
- write_high and ovf are registered with the result and only change when the result changes.
- Invariant: out_valid == (state==HOLD). busy == (state==BUSY).

Test Plan:
- Reset mid-MUL: accept MUL 7*9, then assert rst_n=0 at BUSY cycle 5. All outputs must go to 0 immediately and the state to IDLE. After release, in_ready=1 and no out_valid appears.
- ADD overflow, WIDTH=16: ADD 0x7FFF+0x0001 -> o_low=0x8000, ovf=1, out_valid one cycle after accept. SUB 0x8000-0x0001 -> o_low=0x7FFF, ovf=1. ADD 5+3 -> 8, ovf=0.
- Signed MUL, WIDTH=16, out_ready=1:
  - -3*5 -> {o_high,o_low}=0xFFFF_FFF1, write_high=1, out_valid exactly 17 cycles after accept, busy high for 16 cycles, in_ready low during BUSY.
  - 0x8000*0x8000 -> 0x4000_0000.
  - 0x7FFF*0x7FFF -> 0x3FFF_0001.
- SH: s0=0xABCD, s1=8 -> o_high=0x00AB, o_low=0xCD00, write_high=1. s1=32 -> result 0. s1=0xFFFF -> result 0.
- Backpressure and back-to-back:
  - With out_ready held low, an ADD result stays stable for 5 cycles and in_ready stays 0.
  - Then raise out_ready with a back-to-back XOR, AND, OR, NOT stream: one result per cycle, correct order, write_high=0, no drops or duplicates.
- Random regression: 10k random ops with random in_valid/out_ready toggling at WIDTH=8, 16 and 32. Compare against a reference model of the combinational opcode semantics, extended to WIDTH.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle opcodes produce a result one cycle after accept; MUL runs an
// iterative shift-add over operand magnitudes and finishes WIDTH cycles later.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no result pending, ready for a new operation
// BUSY    | multiplier iterating, one multiplier bit per cycle
// HOLD    | result registers hold an unconsumed result (out_valid = 1)
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] s0,
    input  logic [WIDTH-1:0] s1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o_low,
    output logic [WIDTH-1:0] o_high,
    output logic             write_high,
    output logic             ovf,
    output logic             busy
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_SH  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    // Any shift of 2*WIDTH or more pushes every bit of s0 out of the result.
    localparam logic [WIDTH-1:0] SH_LIMIT = WIDTH'(2 * WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic             accept;
    logic             is_mul;
    logic             mul_last;

    logic [WIDTH-1:0]   sum, diff;
    logic [2*WIDTH-1:0] sh_full;
    logic [WIDTH-1:0]   res_low, res_high;
    logic               res_wh, res_ovf;

    // Magnitudes carry one extra bit so |most-negative| is representable.
    logic [WIDTH:0]     mag0, mag1;
    logic [WIDTH:0]     mplier;
    logic [2*WIDTH-1:0] mcand, acc, acc_nxt, prod;
    logic               mul_neg;
    logic [CNT_W-1:0]   cnt;

    assign in_ready  = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (opcode == OP_MUL);
    assign mul_last  = (state == ST_BUSY) && (cnt == CNT_LAST);
    assign out_valid = (state == ST_HOLD);
    assign busy      = (state == ST_BUSY);

    assign mag0 = s0[WIDTH-1] ? -{s0[WIDTH-1], s0} : {1'b0, s0};
    assign mag1 = s1[WIDTH-1] ? -{s1[WIDTH-1], s1} : {1'b0, s1};

    assign acc_nxt = acc + (mplier[0] ? mcand : '0);
    assign prod    = mul_neg ? -acc_nxt : acc_nxt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a HOLD with out_ready either retires or chains a new op.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = is_mul ? ST_BUSY : ST_HOLD;
                end
            end
            ST_BUSY: begin
                if (mul_last) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (accept) begin
                        state_nxt = is_mul ? ST_BUSY : ST_HOLD;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Single-cycle opcode results, evaluated from the live operands.
    always_comb begin
        sum      = s0 + s1;
        diff     = s0 - s1;
        sh_full  = (s1 >= SH_LIMIT) ? '0 : ({{WIDTH{1'b0}}, s0} << s1);
        res_low  = '0;
        res_high = '0;
        res_wh   = 1'b0;
        res_ovf  = 1'b0;
        case (opcode)
            OP_ADD: begin
                res_low = sum;
                res_ovf = (s0[WIDTH-1] == s1[WIDTH-1]) && (sum[WIDTH-1] != s0[WIDTH-1]);
            end
            OP_SUB: begin
                res_low = diff;
                res_ovf = (s0[WIDTH-1] != s1[WIDTH-1]) && (diff[WIDTH-1] != s0[WIDTH-1]);
            end
            OP_SH: begin
                res_low  = sh_full[WIDTH-1:0];
                res_high = sh_full[2*WIDTH-1:WIDTH];
                res_wh   = 1'b1;
            end
            OP_XOR:  res_low = s0 ^ s1;
            OP_AND:  res_low = s0 & s1;
            OP_OR:   res_low = s0 | s1;
            OP_NOT:  res_low = ~s0;
            default: res_low = '0;
        endcase
    end

    // Result registers and the shift-add multiplier datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_low      <= '0;
            o_high     <= '0;
            write_high <= 1'b0;
            ovf        <= 1'b0;
            mcand      <= '0;
            mplier     <= '0;
            mul_neg    <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
        end else if (accept && is_mul) begin
            mcand   <= {{(WIDTH-1){1'b0}}, mag0};
            mplier  <= mag1;
            mul_neg <= s0[WIDTH-1] ^ s1[WIDTH-1];
            acc     <= '0;
            cnt     <= '0;
        end else if (accept) begin
            o_low      <= res_low;
            o_high     <= res_high;
            write_high <= res_wh;
            ovf        <= res_ovf;
        end else if (state == ST_BUSY) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (mul_last) begin
                o_low      <= prod[WIDTH-1:0];
                o_high     <= prod[2*WIDTH-1:WIDTH];
                write_high <= 1'b1;
                ovf        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks on a 16-bit instance plus a randomized
// regression of 8-, 16- and 32-bit instances against a signed-integer model.
module tb_alu_seq;

    localparam int RND_OPS    = 3400;
    localparam int RND_BUDGET = 60000;

    typedef struct packed {
        logic [63:0] hi;
        logic [63:0] lo;
        logic        wh;
        logic        ovf;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  in_valid, out_ready;
    wire  [2:0]  in_ready, out_valid, write_high, ovf, busy;
    logic [2:0]  opcode [3];
    logic [63:0] s0 [3];
    logic [63:0] s1 [3];
    wire  [63:0] o_low [3];
    wire  [63:0] o_high [3];

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] str_exp [4];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int W = 8 << g;
            wire [W-1:0] lo, hi;
            alu_seq #(.WIDTH(W)) u_dut (
                .clk        (clk),
                .rst_n      (rst_n),
                .in_valid   (in_valid[g]),
                .in_ready   (in_ready[g]),
                .opcode     (opcode[g]),
                .s0         (s0[g][W-1:0]),
                .s1         (s1[g][W-1:0]),
                .out_valid  (out_valid[g]),
                .out_ready  (out_ready[g]),
                .o_low      (lo),
                .o_high     (hi),
                .write_high (write_high[g]),
                .ovf        (ovf[g]),
                .busy       (busy[g])
            );
            assign o_low[g]  = 64'(lo);
            assign o_high[g] = 64'(hi);
        end
    endgenerate

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: true signed arithmetic, then range test and truncation.
    function automatic res_t ref_model(input int w, input logic [2:0] op,
                                       input logic [63:0] a, input logic [63:0] b);
        res_t        r;
        longint      sa, sb, t, lim;
        logic [63:0] mask, full;
        mask = (64'd1 << w) - 64'd1;
        sa   = $signed(a << (64 - w)) >>> (64 - w);
        sb   = $signed(b << (64 - w)) >>> (64 - w);
        lim  = longint'(64'd1 << (w - 1));
        r    = '0;
        case (op)
            3'd0: begin
                t     = sa + sb;
                r.lo  = 64'(t) & mask;
                r.ovf = (t >= lim) || (t < -lim);
            end
            3'd1: begin
                t     = sa - sb;
                r.lo  = 64'(t) & mask;
                r.ovf = (t >= lim) || (t < -lim);
            end
            3'd2: begin
                t    = sa * sb;
                r.lo = 64'(t) & mask;
                r.hi = (64'(t) >> w) & mask;
                r.wh = 1'b1;
            end
            3'd3: begin
                r.wh = 1'b1;
                if (b < 64'(2 * w)) begin
                    full = a << b;
                    r.lo = full & mask;
                    r.hi = (full >> w) & mask;
                end
            end
            3'd4:    r.lo = a ^ b;
            3'd5:    r.lo = a & b;
            3'd6:    r.lo = a | b;
            default: r.lo = ~a & mask;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] rand_operand(input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return mask >> 1;
            2:       return 64'd1 << (w - 1);
            3:       return mask;
            default: return {$urandom, $urandom} & mask;
        endcase
    endfunction

    // One operation on the 16-bit instance with out_ready held high.
    task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input int lat_exp, input logic [31:0] res_exp,
                          input logic wh_exp, input logic ovf_exp, input string tag);
        int lat, busy_n, rdy_bad;
        @(negedge clk);
        opcode[1]    = op;
        s0[1]        = 64'(a);
        s1[1]        = 64'(b);
        in_valid[1]  = 1'b1;
        out_ready[1] = 1'b1;
        #1;
        check({tag, "_in_ready"}, in_ready[1], 1);
        @(negedge clk);
        in_valid[1] = 1'b0;
        s0[1]       = 64'($urandom_range(0, 65535));
        s1[1]       = 64'($urandom_range(0, 65535));
        lat     = 1;
        busy_n  = 0;
        rdy_bad = 0;
        while (!out_valid[1] && lat < 100) begin
            if (busy[1]) busy_n++;
            if (in_ready[1]) rdy_bad++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, lat_exp);
        check({tag, "_result"}, {o_high[1][15:0], o_low[1][15:0]}, res_exp);
        check({tag, "_write_high"}, write_high[1], wh_exp);
        check({tag, "_ovf"}, ovf[1], ovf_exp);
        if (op == 3'd2) begin
            check({tag, "_busy_cycles"}, busy_n, 16);
            check({tag, "_ready_in_busy"}, rdy_bad, 0);
        end
    endtask

    initial begin
        int    w, cyc, bad, seen;
        int    n_done [3];
        bit    pend [3];
        res_t  exp_r [3];

        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = '0;
        for (int g = 0; g < 3; g++) begin
            opcode[g] = '0;
            s0[g]     = '0;
            s1[g]     = '0;
            n_done[g] = 0;
            pend[g]   = 1'b0;
            exp_r[g]  = '0;
        end
        str_exp[0] = 16'hCCCC;
        str_exp[1] = 16'h3030;
        str_exp[2] = 16'hFCFC;
        str_exp[3] = 16'h0F0F;

        repeat (3) @(negedge clk);
        check("reset_flags", {out_valid[1], busy[1], write_high[1], ovf[1], in_ready[1]}, 5'b00001);
        check("reset_result", {o_high[1], o_low[1]}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_flags", {out_valid[1], busy[1], in_ready[1]}, 3'b001);

        run_op(3'd0, 16'h7FFF, 16'h0001, 1, 32'h0000_8000, 1'b0, 1'b1, "add_ovf");
        run_op(3'd1, 16'h8000, 16'h0001, 1, 32'h0000_7FFF, 1'b0, 1'b1, "sub_ovf");
        run_op(3'd0, 16'h0005, 16'h0003, 1, 32'h0000_0008, 1'b0, 1'b0, "add_small");
        run_op(3'd2, 16'hFFFD, 16'h0005, 17, 32'hFFFF_FFF1, 1'b1, 1'b0, "mul_neg");
        run_op(3'd2, 16'h8000, 16'h8000, 17, 32'h4000_0000, 1'b1, 1'b0, "mul_minmin");
        run_op(3'd2, 16'h7FFF, 16'h7FFF, 17, 32'h3FFF_0001, 1'b1, 1'b0, "mul_maxmax");
        run_op(3'd3, 16'hABCD, 16'd8, 1, 32'h00AB_CD00, 1'b1, 1'b0, "sh_8");
        run_op(3'd3, 16'hABCD, 16'd32, 1, 32'h0000_0000, 1'b1, 1'b0, "sh_32");
        run_op(3'd3, 16'hABCD, 16'hFFFF, 1, 32'h0000_0000, 1'b1, 1'b0, "sh_ffff");

        // Abort a multiply with reset after leaving a non-zero result behind.
        run_op(3'd0, 16'h7FFF, 16'h0001, 1, 32'h0000_8000, 1'b0, 1'b1, "add_pre_rst");
        @(negedge clk);
        opcode[1]   = 3'd2;
        s0[1]       = 64'd7;
        s1[1]       = 64'd9;
        in_valid[1] = 1'b1;
        @(negedge clk);
        in_valid[1] = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_mid_busy", busy[1], 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_flags", {out_valid[1], busy[1], write_high[1], ovf[1]}, 0);
        check("rst_mid_result", {o_high[1], o_low[1]}, 0);
        check("rst_mid_in_ready", in_ready[1], 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid[1]) seen++;
        end
        check("rst_no_result", seen, 0);
        check("rst_release_ready", in_ready[1], 1);

        // Backpressure: ADD result held while out_ready is low.
        @(negedge clk);
        opcode[1]    = 3'd0;
        s0[1]        = 64'h1234;
        s1[1]        = 64'h0101;
        in_valid[1]  = 1'b1;
        out_ready[1] = 1'b0;
        @(negedge clk);
        in_valid[1] = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!(out_valid[1] && !in_ready[1] && o_low[1] == 64'h1335 && !ovf[1])) bad++;
            if (i < 4) @(negedge clk);
        end
        check("bp_hold_stable", bad, 0);

        // Back-to-back logic ops, one result per cycle.
        out_ready[1] = 1'b1;
        s0[1]        = 64'hF0F0;
        s1[1]        = 64'h3C3C;
        for (int i = 0; i < 4; i++) begin
            opcode[1]   = 3'(4 + i);
            in_valid[1] = 1'b1;
            @(negedge clk);
            check($sformatf("b2b_%0d_result", i), o_low[1], 64'(str_exp[i]));
            check($sformatf("b2b_%0d_flags", i), {out_valid[1], write_high[1], o_high[1][15:0]}, 18'h20000);
        end
        in_valid[1] = 1'b0;
        @(negedge clk);
        check("b2b_drain", out_valid[1], 0);

        // Randomized regression across all three widths.
        cyc = 0;
        while ((n_done[0] < RND_OPS || n_done[1] < RND_OPS || n_done[2] < RND_OPS) && cyc < RND_BUDGET) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                w            = 8 << g;
                in_valid[g]  = ($urandom_range(0, 3) != 0);
                out_ready[g] = ($urandom_range(0, 3) != 0);
                opcode[g]    = 3'($urandom_range(0, 7));
                s0[g]        = rand_operand(w);
                if (opcode[g] == 3'd3 && $urandom_range(0, 1) == 1)
                    s1[g] = 64'($urandom_range(0, 2 * w + 4));
                else
                    s1[g] = rand_operand(w);
            end
            #1;
            for (int g = 0; g < 3; g++) begin
                w = 8 << g;
                if (out_valid[g] && out_ready[g]) begin
                    if (!pend[g]) begin
                        check($sformatf("rnd_w%0d_unexpected", w), 1, 0);
                    end else begin
                        check($sformatf("rnd_w%0d_result", w), {o_high[g], o_low[g]}, {exp_r[g].hi, exp_r[g].lo});
                        check($sformatf("rnd_w%0d_flags", w), {write_high[g], ovf[g]}, {exp_r[g].wh, exp_r[g].ovf});
                    end
                    pend[g] = 1'b0;
                    n_done[g]++;
                end
                if (in_valid[g] && in_ready[g]) begin
                    exp_r[g] = ref_model(w, opcode[g], s0[g], s1[g]);
                    pend[g]  = 1'b1;
                end
            end
            cyc++;
        end
        check("rnd_cycle_budget", (cyc < RND_BUDGET), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
